// File: rtl/cpu15_pkg.sv
// Shared definitions for the cpu15 core: write-back mode encodings and
// register file geometry.
package cpu15_pkg;

    localparam int CPU_DATA_W  = 16;
    localparam int CPU_N_REG_W = 3;
    localparam int CPU_NUM_REG = 2 ** CPU_N_REG_W;

    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_FULL = 2'b01,
        WB_LO   = 2'b10,
        WB_HI   = 2'b11
    } wb_mode_e;

    function automatic logic is_write(input logic [1:0] mode);
        return (mode != WB_NONE);
    endfunction

endpackage

// File: rtl/reg_merge.sv
// Combinational byte merge of a write-back result into an existing register
// value; shared by the commit stage and decode-side forwarding.
module reg_merge
    import cpu15_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] data,
    input  wb_mode_e          mode,
    output logic [DATA_W-1:0] new_val
);

    // Select the merged word; WB_NONE leaves the register unchanged.
    always_comb begin
        new_val = old_val;
        case (mode)
            WB_FULL: new_val = data;
            WB_LO:   new_val = {old_val[DATA_W-1:8], data[7:0]};
            WB_HI:   new_val = {data[7:0], old_val[7:0]};
            WB_NONE: new_val = old_val;
            default: new_val = old_val;
        endcase
    end

endmodule

// File: rtl/reg_wb.sv
// Register write-back stage: two-stage capture/commit pipeline that owns the
// 8 x 16-bit general register file and publishes it to decode.
module reg_wb
    import cpu15_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int N_REG_W = CPU_N_REG_W
) (
    input  logic               CLK_WB,
    input  logic               RESET,
    input  logic               WB_EN,
    input  logic [1:0]         WB_MODE,
    input  logic [N_REG_W-1:0] N_REG_IN,
    input  logic [DATA_W-1:0]  DATA_IN,
    output logic [DATA_W-1:0]  REG_0,
    output logic [DATA_W-1:0]  REG_1,
    output logic [DATA_W-1:0]  REG_2,
    output logic [DATA_W-1:0]  REG_3,
    output logic [DATA_W-1:0]  REG_4,
    output logic [DATA_W-1:0]  REG_5,
    output logic [DATA_W-1:0]  REG_6,
    output logic [DATA_W-1:0]  REG_7,
    output logic               PEND,
    output logic [N_REG_W-1:0] N_REG_PEND,
    output logic               WB_DONE,
    output logic [N_REG_W-1:0] N_REG_DONE
);

    localparam int NUM_REG = 2 ** N_REG_W;

    logic [DATA_W-1:0]  regs_r [NUM_REG];
    logic               cap_valid_r;
    wb_mode_e           cap_mode_r;
    logic [N_REG_W-1:0] cap_idx_r;
    logic [DATA_W-1:0]  cap_data_r;
    logic               done_r;
    logic [N_REG_W-1:0] done_idx_r;
    logic [DATA_W-1:0]  merge_s;

    // Stage 1: latch a valid request; anything else drops the pending flag.
    always_ff @(posedge CLK_WB) begin
        if (RESET) begin
            cap_valid_r <= 1'b0;
            cap_mode_r  <= WB_NONE;
            cap_idx_r   <= {N_REG_W{1'b0}};
            cap_data_r  <= {DATA_W{1'b0}};
        end else if (WB_EN && is_write(WB_MODE)) begin
            cap_valid_r <= 1'b1;
            cap_mode_r  <= wb_mode_e'(WB_MODE);
            cap_idx_r   <= N_REG_IN;
            cap_data_r  <= DATA_IN;
        end else begin
            cap_valid_r <= 1'b0;
        end
    end

    // The merge base is the live register, which already holds the previous
    // commit, so back-to-back byte writes to one register compose correctly.
    reg_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_val (regs_r[cap_idx_r]),
        .data    (cap_data_r),
        .mode    (cap_mode_r),
        .new_val (merge_s)
    );

    // Stage 2: commit the captured write and pulse the done indication.
    always_ff @(posedge CLK_WB) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            done_r     <= 1'b0;
            done_idx_r <= {N_REG_W{1'b0}};
        end else begin
            done_r <= cap_valid_r;
            if (cap_valid_r) begin
                regs_r[cap_idx_r] <= merge_s;
                done_idx_r        <= cap_idx_r;
            end
        end
    end

    assign REG_0      = regs_r[0];
    assign REG_1      = regs_r[1];
    assign REG_2      = regs_r[2];
    assign REG_3      = regs_r[3];
    assign REG_4      = regs_r[4];
    assign REG_5      = regs_r[5];
    assign REG_6      = regs_r[6];
    assign REG_7      = regs_r[7];
    assign PEND       = cap_valid_r;
    assign N_REG_PEND = cap_idx_r;
    assign WB_DONE    = done_r;
    assign N_REG_DONE = done_idx_r;

endmodule

// File: tb/tb_reg_wb.sv
// Self-checking bench for reg_wb: a reference register model produces the
// expected commit for each request, queued until the DUT reports the commit.
module tb_reg_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [1:0]  wb_mode;
    logic [2:0]  idx_in;
    logic [15:0] din;
    logic [15:0] reg_out [8];
    logic        pend;
    logic [2:0]  pend_idx;
    logic        done;
    logic [2:0]  done_idx;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] val;
    } item_t;

    item_t       sb[$];
    logic [15:0] model [8];
    bit          prev_cap;
    int          total;
    int          bad;

    reg_wb dut (
        .CLK_WB     (clk),
        .RESET      (rst),
        .WB_EN      (wb_en),
        .WB_MODE    (wb_mode),
        .N_REG_IN   (idx_in),
        .DATA_IN    (din),
        .REG_0      (reg_out[0]),
        .REG_1      (reg_out[1]),
        .REG_2      (reg_out[2]),
        .REG_3      (reg_out[3]),
        .REG_4      (reg_out[4]),
        .REG_5      (reg_out[5]),
        .REG_6      (reg_out[6]),
        .REG_7      (reg_out[7]),
        .PEND       (pend),
        .N_REG_PEND (pend_idx),
        .WB_DONE    (done),
        .N_REG_DONE (done_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_merge(input logic [15:0] old, input logic [1:0] mode,
                                              input logic [15:0] d);
        case (mode)
            2'b01:   return d;
            2'b10:   return {old[15:8], d[7:0]};
            2'b11:   return {d[7:0], old[7:0]};
            default: return old;
        endcase
    endfunction

    task automatic check_all();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("reg%0d", i), {16'h0000, reg_out[i]}, {16'h0000, model[i]});
        end
    endtask

    // Drive one request for one edge, then check capture and commit outputs.
    task automatic step(input logic en, input logic [1:0] mode, input logic [2:0] i,
                        input logic [15:0] d);
        bit    cap;
        item_t it;
        wb_en   = en;
        wb_mode = mode;
        idx_in  = i;
        din     = d;
        cap     = en && (mode != 2'b00);
        if (cap) begin
            model[i] = ref_merge(model[i], mode, d);
            sb.push_back('{idx: i, val: model[i]});
        end
        @(posedge clk);
        #1;
        chk("pend", {31'd0, pend}, {31'd0, cap});
        if (cap) chk("pend_idx", {29'd0, pend_idx}, {29'd0, i});
        chk("done", {31'd0, done}, {31'd0, prev_cap});
        if (prev_cap && sb.size() > 0) begin
            it = sb.pop_front();
            chk("done_idx", {29'd0, done_idx}, {29'd0, it.idx});
            chk("commit_val", {16'h0000, reg_out[it.idx]}, {16'h0000, it.val});
        end
        prev_cap = cap;
    endtask

    // Reset with a competing write request present, which must lose.
    task automatic do_reset();
        rst     = 1'b1;
        wb_en   = 1'b1;
        wb_mode = 2'b01;
        idx_in  = 3'd3;
        din     = 16'hFFFF;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wb_en = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        sb.delete();
        prev_cap = 1'b0;
        chk("rst_pend", {31'd0, pend}, 32'd0);
        chk("rst_pend_idx", {29'd0, pend_idx}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_done_idx", {29'd0, done_idx}, 32'd0);
        check_all();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        prev_cap = 1'b0;
        rst      = 1'b1;
        wb_en    = 1'b0;
        wb_mode  = 2'b00;
        idx_in   = 3'd0;
        din      = 16'h0000;
        @(posedge clk);
        #1;

        // 1: reset and idle
        do_reset();
        step(1'b0, 2'b00, 3'd0, 16'h0000);
        check_all();

        // 2: single full write with latency checks
        step(1'b1, 2'b01, 3'd5, 16'hA5C3);
        step(1'b0, 2'b00, 3'd0, 16'h0000);
        chk("r5_const", {16'h0000, reg_out[5]}, 32'h0000A5C3);
        step(1'b0, 2'b00, 3'd0, 16'h0000);

        // 3: LDL then LDH to R2 on consecutive edges
        step(1'b1, 2'b10, 3'd2, 16'h0034);
        step(1'b1, 2'b11, 3'd2, 16'h0012);
        chk("r2_lo", {16'h0000, reg_out[2]}, 32'h00000034);
        step(1'b0, 2'b00, 3'd0, 16'h0000);
        chk("r2_both", {16'h0000, reg_out[2]}, 32'h00001234);
        check_all();

        // 4: continuous stream R0..R7
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'b01, 3'(i), 16'(16'h1111 * i));
        end
        step(1'b0, 2'b00, 3'd0, 16'h0000);
        check_all();

        // 5: reset on the commit edge drops the write
        step(1'b1, 2'b01, 3'd3, 16'hFFFF);
        do_reset();
        step(1'b0, 2'b00, 3'd0, 16'h0000);
        chk("r3_lost", {16'h0000, reg_out[3]}, 32'h00000000);

        // 6: ignored requests
        step(1'b1, 2'b01, 3'd4, 16'h4444);
        step(1'b1, 2'b00, 3'd4, 16'hBEEF);
        step(1'b0, 2'b01, 3'd4, 16'hCAFE);
        step(1'b0, 2'b00, 3'd0, 16'h0000);
        check_all();

        // random mix of modes, indices and idle cycles
        for (int n = 0; n < 40; n++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 16'($urandom));
        end
        step(1'b0, 2'b00, 3'd0, 16'h0000);
        step(1'b0, 2'b00, 3'd0, 16'h0000);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_wb.md
Name: reg_wb

Overview:
- Register write-back stage and owner of the 8 x 16-bit general register file.
- Writes results into the register file; the decode stage reads them.
- Accepts one write-back request per CLK_WB edge from the execute stage through a 2-stage pipeline: capture, then commit.
- Supports full-word, low-byte and high-byte writes for MOV/ALU and LDL/LDH results.
- Publishes all registers as REG_0..REG_7 and a pending-write hazard indication to the decode stage.

Parameters:
- DATA_W, 16, register width in bits. Byte modes assume DATA_W = 16.
- N_REG_W, 3, register index width (2**N_REG_W = 8 registers).

Ports:
- CLK_WB  in  1  stage clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- WB_EN  in  1  write-back request valid this cycle.
- WB_MODE  in  2  00 = no write, 01 = full word, 10 = low byte, 11 = high byte.
- N_REG_IN  in  3  destination register index.
- DATA_IN  in  16  result data. Byte modes use DATA_IN[7:0] as the byte.
- REG_0..REG_7  out  16 each  current architectural register contents.
- PEND  out  1  a captured write is awaiting commit.
- N_REG_PEND  out  3  destination index of the pending write (valid when PEND = 1).
- WB_DONE  out  1  one-cycle pulse: a write committed on the last edge.
- N_REG_DONE  out  3  index of the write just committed.

Behaviour:
- Reset
  - Synchronous on the CLK_WB edge while RESET = 1.
  - All REG_x = 16'h0000. PEND = 0, N_REG_PEND = 0, WB_DONE = 0, N_REG_DONE = 0.
  - The capture stage is cleared, so an in-flight request is dropped and never committed.
  - RESET takes priority over any simultaneous WB_EN.
- Stage 1, capture
  - On an edge with WB_EN = 1 and WB_MODE != 00, latch mode, index and data, and set the pending-valid flag.
  - Otherwise clear the pending-valid flag.
  - PEND is the pending-valid flag. N_REG_PEND is the latched index.
- Stage 2, commit
  - On the next edge after a capture, update the target register:
    - 01 (full word): reg = data.
    - 10 (low byte): reg = {reg[15:8], data[7:0]}.
    - 11 (high byte): reg = {data[7:0], reg[7:0]}.
  - On that same edge set WB_DONE = 1 and N_REG_DONE = index. Otherwise WB_DONE = 0.
- Latency
  - Request presented at edge n is visible on REG_x after edge n+1.
  - PEND is high between edge n and edge n+1.
- Throughput
  - One request per cycle, with no stall.
  - Capture of request k+1 and commit of request k occur on the same edge.
- Back-to-back to the same register (byte-merge ordering)
  - The commit of request k+1 merges against the value just written by request k, never the stale register.
  - Example: LDL then LDH on R2 yields both bytes.
  - Requirement: the RMW base is the register contents after the preceding commit.
- Requests with WB_EN = 0, or with WB_EN = 1 and WB_MODE = 00, are ignored. PEND stays low and nothing commits.
- Indices are 3-bit and address all 8 registers. No out-of-range case exists.
- Registers not addressed by a commit hold their value.
- The decode stage stalls while PEND = 1 and N_REG_PEND matches a source operand. This block does not stall itself.

Decomposition:
- Shared package (cpu15_pkg) holds:
  - WB_MODE encodings: WB_NONE, WB_FULL, WB_LO, WB_HI.
  - Register count and width constants.
- One sub-module, reg_merge: combinational byte-merge of (old, data, mode) to new.
  - Used by the commit stage.
  - Reusable by decode-side forwarding.

Test Plan:
1. Reset, then idle → all REG_x = 0000, PEND = 0, WB_DONE = 0.
2. WB_EN = 1, WB_MODE = 01, N_REG_IN = 5, DATA_IN = A5C3 at edge n:
   - PEND = 1 and N_REG_PEND = 5 after edge n.
   - REG_5 = A5C3, WB_DONE = 1 and N_REG_DONE = 5 after edge n+1.
   - PEND and WB_DONE return to 0 after edge n+2.
3. Consecutive cycles: LDL R2 with DATA_IN = 0034, then LDH R2 with DATA_IN = 0012 → REG_2 = 0034, then 1234. No cycle gap between the two requests.
4. Continuous stream writing R0..R7 with values 1111·i → each REG_i = 1111·i exactly one edge after capture. WB_DONE stays high for 8 cycles.
5. Full write R3 = FFFF captured, then RESET asserted on the commit edge → REG_3 = 0000, PEND = 0, WB_DONE = 0. The write is lost.
6. WB_EN = 1 with WB_MODE = 00, and WB_EN = 0 with WB_MODE = 01 → no register changes, PEND = 0, WB_DONE = 0.
